// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer.
// State codes, field widths and the 0..59 preset clamp.
package countdown_pkg;

  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int HUND_W   = 7;
  localparam int MAX_SECS = 59;
  localparam int MAX_HUND = 99;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_EXP   = 2'd3;

  function automatic logic [5:0] sat59(
    input logic [5:0] v
  );
    return (v > 6'(MAX_SECS)) ? 6'(MAX_SECS) : v;
  endfunction

endpackage

// File: rtl/countdown_tick_gen.sv
// Hundredths time base: counts enabled cycles, ticks on TICK_DIV-1.
// Holds while disabled; synchronous clear has priority.
module countdown_tick_gen #(
  parameter int TICK_DIV = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// mm:ss.hh countdown with start/pause/ack button and preset load.
// COUNTDOWN_AUTO_RELOAD_EN: reload preset on expiry, one-cycle alarm.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int TICK_DIV = 500_000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              startStop,
  input  logic              load,
  input  logic [MIN_W-1:0]  set_mins,
  input  logic [SEC_W-1:0]  set_secs,
  output logic [MIN_W-1:0]  mins,
  output logic [SEC_W-1:0]  secs,
  output logic [HUND_W-1:0] hundredths,
  output logic              running,
  output logic              alarm
);

  logic              ss_prev, ld_prev;
  logic              ss_p, ld_p;
  logic [1:0]        state;
  logic [MIN_W-1:0]  pre_m;
  logic [SEC_W-1:0]  pre_s;
  logic              tick, div_clr, div_en;
  logic [MIN_W-1:0]  m_dec;
  logic [SEC_W-1:0]  s_dec;
  logic [HUND_W-1:0] h_dec;
  logic              at_one, nonzero, stop_exp;

  assign ss_p    = startStop & ~ss_prev;
  assign ld_p    = load & ~ld_prev;
  assign running = (state == S_RUN);
  assign nonzero = (mins != '0) || (secs != '0) || (hundredths != '0);
  assign at_one  = (mins == '0) && (secs == '0) && (hundredths == 7'd1);
  assign div_en  = (state == S_RUN);
  assign div_clr = ld_p | (ss_p & (state == S_IDLE) & nonzero);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  assign stop_exp = 1'b0;
`else
  assign stop_exp = tick & at_one;
`endif

  countdown_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (div_en),
    .clr    (div_clr),
    .tick   (tick)
  );

  always_comb begin
    h_dec = hundredths - 7'd1;
    s_dec = secs;
    m_dec = mins;
    if (hundredths == '0) begin
      h_dec = 7'(MAX_HUND);
      s_dec = secs - 6'd1;
      if (secs == '0) begin
        s_dec = 6'(MAX_SECS);
        m_dec = mins - 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_prev    <= 1'b0;
      ld_prev    <= 1'b0;
      state      <= S_IDLE;
      mins       <= '0;
      secs       <= '0;
      hundredths <= '0;
      pre_m      <= '0;
      pre_s      <= '0;
      alarm      <= 1'b0;
    end else begin
      ss_prev <= startStop;
      ld_prev <= load;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
      alarm   <= 1'b0;
`endif
      if (ld_p) begin
        mins       <= sat59(set_mins);
        secs       <= sat59(set_secs);
        hundredths <= '0;
        pre_m      <= sat59(set_mins);
        pre_s      <= sat59(set_secs);
        alarm      <= 1'b0;
        state      <= S_IDLE;
      end else begin
        if (tick) begin
          if (at_one) begin
            alarm <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            mins       <= pre_m;
            secs       <= pre_s;
            hundredths <= '0;
`else
            hundredths <= '0;
            state      <= S_EXP;
`endif
          end else begin
            mins       <= m_dec;
            secs       <= s_dec;
            hundredths <= h_dec;
          end
        end
        // expiry on the same edge as a pause press wins
        if (ss_p) begin
          unique case (state)
            S_IDLE:  if (nonzero) state <= S_RUN;
            S_RUN:   if (!stop_exp) state <= S_PAUSE;
            S_PAUSE: state <= S_RUN;
            S_EXP: begin
              state <= S_IDLE;
              alarm <= 1'b0;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer with TICK_DIV = 4.
// Directed scenarios plus random buttons against a hundredths-total model.
module tb_countdown_timer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       startStop = 1'b0;
  logic       load = 1'b0;
  logic [5:0] set_mins = '0;
  logic [5:0] set_secs = '0;
  logic [5:0] mins;
  logic [5:0] secs;
  logic [6:0] hundredths;
  logic       running;
  logic       alarm;

  int errors = 0;
  int checks = 0;

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .startStop (startStop),
    .load      (load),
    .set_mins  (set_mins),
    .set_secs  (set_secs),
    .mins      (mins),
    .secs      (secs),
    .hundredths(hundredths),
    .running   (running),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_EXP} mst_e;
  typedef struct {
    mst_e st;
    int   total;
    int   preset;
    int   phase;
    bit   alarm;
    bit   pl;
    bit   ps;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t mreset();
    mdl_t r;
    r.st = M_IDLE; r.total = 0; r.preset = 0; r.phase = 0;
    r.alarm = 0; r.pl = 0; r.ps = 0;
    return r;
  endfunction

  function automatic mdl_t mstep(mdl_t c, bit ld, bit ss, int sm, int sc);
    mdl_t n = c;
    bit lp = ld && !c.pl;
    bit sp = ss && !c.ps;
    n.pl = ld;
    n.ps = ss;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    n.alarm = 0;
`endif
    if (lp) begin
      n.total  = (sm > 59 ? 59 : sm) * 6000 + (sc > 59 ? 59 : sc) * 100;
      n.preset = n.total;
      n.phase  = 0;
      n.alarm  = 0;
      n.st     = M_IDLE;
      return n;
    end
    if (c.st == M_RUN) begin
      n.phase = c.phase + 1;
      if (n.phase == TD) begin
        n.phase = 0;
        n.total = c.total - 1;
        if (n.total == 0) begin
          n.alarm = 1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          n.total = c.preset;
`else
          n.st = M_EXP;
`endif
        end
      end
    end
    if (sp) begin
      if (c.st == M_IDLE) begin
        if (c.total != 0) begin
          n.st = M_RUN;
          n.phase = 0;
        end
      end else if (c.st == M_RUN) begin
        if (n.st == M_RUN) n.st = M_PAUSE;
      end else if (c.st == M_PAUSE) begin
        n.st = M_RUN;
      end else begin
        n.st = M_IDLE;
        n.alarm = 0;
      end
    end
    return n;
  endfunction

  function automatic logic [20:0] mvec(mdl_t c);
    return {6'(c.total / 6000), 6'((c.total / 100) % 60),
            7'(c.total % 100), c.st == M_RUN, c.alarm};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m <= mreset();
    else m <= mstep(m, load, startStop, int'(set_mins), int'(set_secs));
  end

  task automatic tick_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_load(input int mm, input int ss);
    set_mins = 6'(mm);
    set_secs = 6'(ss);
    load = 1'b1;
    tick_n(1);
    load = 1'b0;
  endtask

  task automatic pulse_ss();
    startStop = 1'b1;
    tick_n(1);
    startStop = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick_n(3);
    if ({mins, secs, hundredths, running, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL reset: got %h want 0", {mins, secs, hundredths, running, alarm});
    end
    checks++;
    reset_n = 1'b1;
    tick_n(2);
  endtask

  task automatic test_load_first_dec();
    pulse_load(1, 0);
    pulse_ss();
    tick_n(3);
    if ({mins, secs, hundredths} !== {6'd1, 6'd0, 7'd0} || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_dec: got %0d:%0d.%0d run=%b want 1:0.0 run=1",
               mins, secs, hundredths, running);
    end
    checks++;
    tick_n(1);
    if ({mins, secs, hundredths} !== {6'd0, 6'd59, 7'd99} || running !== 1'b1) begin
      errors++;
      $display("FAIL first_dec: got %0d:%0d.%0d run=%b want 0:59.99 run=1",
               mins, secs, hundredths, running);
    end
    checks++;
  endtask

  task automatic test_expiry();
    pulse_load(0, 1);
    pulse_ss();
    tick_n(399);
    if ({mins, secs, hundredths} !== {6'd0, 6'd0, 7'd1} || running !== 1'b1) begin
      errors++;
      $display("FAIL pre_expiry: got %0d:%0d.%0d run=%b want 0:0.1 run=1",
               mins, secs, hundredths, running);
    end
    checks++;
    tick_n(1);
    if ({mins, secs, hundredths, running, alarm} !== 21'd1) begin
      errors++;
      $display("FAIL expiry: got %h want 000001", {mins, secs, hundredths, running, alarm});
    end
    checks++;
    tick_n(3);
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_hold: got %b want 1", alarm);
    end
    checks++;
    pulse_ss();
    if ({mins, secs, hundredths, running, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL ack: got %h want 0", {mins, secs, hundredths, running, alarm});
    end
    checks++;
    tick_n(1);
    pulse_ss();
    tick_n(5);
    if ({mins, secs, hundredths, running, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL zero_start: got %h want 0", {mins, secs, hundredths, running, alarm});
    end
    checks++;
  endtask

  task automatic test_pause();
    int bad = 0;
    pulse_load(0, 5);
    pulse_ss();
    tick_n(1);
    pulse_ss();
    for (int i = 0; i < 50; i++) begin
      if ({mins, secs, hundredths} != {6'd0, 6'd5, 7'd0} || running) bad++;
      tick_n(1);
    end
    if (bad != 0) begin
      errors++;
      $display("FAIL pause_hold: %0d cycles moved, want 0", bad);
    end
    checks++;
    pulse_ss();
    tick_n(1);
    if ({mins, secs, hundredths} !== {6'd0, 6'd5, 7'd0} || running !== 1'b1) begin
      errors++;
      $display("FAIL resume_1: got %0d:%0d.%0d run=%b want 0:5.0 run=1",
               mins, secs, hundredths, running);
    end
    checks++;
    tick_n(1);
    if ({mins, secs, hundredths} !== {6'd0, 6'd4, 7'd99}) begin
      errors++;
      $display("FAIL resume_2: got %0d:%0d.%0d want 0:4.99", mins, secs, hundredths);
    end
    checks++;
  endtask

  task automatic test_saturation();
    pulse_load(63, 60);
    if ({mins, secs, hundredths} !== {6'd59, 6'd59, 7'd0} || running !== 1'b0) begin
      errors++;
      $display("FAIL saturate: got %0d:%0d.%0d run=%b want 59:59.0 run=0",
               mins, secs, hundredths, running);
    end
    checks++;
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    tick_n(1);
    pulse_ss();
    tick_n(6);
    if ({mins, secs, hundredths, running, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL start_guard: got %h want 0", {mins, secs, hundredths, running, alarm});
    end
    checks++;
  endtask

  task automatic test_collision();
    pulse_load(0, 9);
    pulse_ss();
    tick_n(6);
    set_mins = 6'd2;
    set_secs = 6'd30;
    load = 1'b1;
    startStop = 1'b1;
    tick_n(1);
    load = 1'b0;
    startStop = 1'b0;
    if ({mins, secs, hundredths} !== {6'd2, 6'd30, 7'd0} || running !== 1'b0) begin
      errors++;
      $display("FAIL collide: got %0d:%0d.%0d run=%b want 2:30.0 run=0",
               mins, secs, hundredths, running);
    end
    checks++;
    tick_n(8);
    if ({mins, secs, hundredths} !== {6'd2, 6'd30, 7'd0} || running !== 1'b0) begin
      errors++;
      $display("FAIL collide_idle: got %0d:%0d.%0d run=%b want 2:30.0 run=0",
               mins, secs, hundredths, running);
    end
    checks++;
  endtask

  task automatic test_reset_midrun();
    pulse_load(3, 3);
    pulse_ss();
    tick_n(10);
    #3 reset_n = 1'b0;
    #1;
    if ({mins, secs, hundredths, running, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", {mins, secs, hundredths, running, alarm});
    end
    checks++;
    tick_n(2);
    reset_n = 1'b1;
    tick_n(2);
    if ({mins, secs, hundredths, running, alarm} !== 21'd0) begin
      errors++;
      $display("FAIL post_reset: got %h want 0", {mins, secs, hundredths, running, alarm});
    end
    checks++;
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    pulse_load(0, 1);
    pulse_ss();
    tick_n(399);
    if (alarm !== 1'b0 || hundredths !== 7'd1) begin
      errors++;
      $display("FAIL reload_pre: got h=%0d alarm=%b want 1 0", hundredths, alarm);
    end
    checks++;
    tick_n(1);
    if ({mins, secs, hundredths, running, alarm} !== {6'd0, 6'd1, 7'd0, 2'b11}) begin
      errors++;
      $display("FAIL reload: got %0d:%0d.%0d run=%b al=%b want 0:1.0 1 1",
               mins, secs, hundredths, running, alarm);
    end
    checks++;
    tick_n(1);
    if (alarm !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL reload_pulse: alarm=%b run=%b want 0 1", alarm, running);
    end
    checks++;
  endtask
`endif

  task automatic test_random();
    int bad = 0;
    int ld_pct, ss_pct;
    for (int seg = 0; seg < 12; seg++) begin
      if (seg % 2 == 0) begin
        ld_pct = 30; ss_pct = 100;
      end else begin
        ld_pct = 2; ss_pct = 6;
      end
      for (int i = 0; i < 400; i++) begin
        if ({mins, secs, hundredths, running, alarm} !== mvec(m)) begin
          bad++;
          if (bad <= 5)
            $display("FAIL random: seg %0d cyc %0d got %h want %h", seg, i,
                     {mins, secs, hundredths, running, alarm}, mvec(m));
        end
        load = ($urandom_range(0, 999) < ld_pct);
        startStop = ($urandom_range(0, 999) < ss_pct);
        set_mins = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
        set_secs = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                : 6'($urandom_range(0, 2));
        tick_n(1);
      end
    end
    if (bad != 0) errors++;
    checks++;
    load = 1'b0;
    startStop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_first_dec();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    pulse_load(0, 0);
    tick_n(1);
    test_auto_reload();
    pulse_load(0, 0);
    tick_n(1);
`else
    test_expiry();
`endif
    test_pause();
    test_saturation();
    test_collision();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown counterpart to the stopwatch. It loads a minutes/seconds preset, then counts down in hundredths of a second to 00:00.00 and raises an alarm when it gets there. It shares the stopwatch's 100 Hz time base and its start/stop button semantics, and drives the same mins/secs/hundredths display path.

## Interface
Parameters:
- TICK_DIV, 500_000: clock cycles per hundredth of a second (500_000 gives 100 Hz from a 50 MHz clk).

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- startStop  input  1  start/pause/resume/acknowledge button; synchronous and debounced upstream; acts on its rising edge.
- load  input  1  preset-load button; synchronous and debounced; acts on its rising edge.
- set_mins  input  6  preset minutes; saturates to 59.
- set_secs  input  6  preset seconds; saturates to 59.
- mins  output  6  remaining minutes, 0..59.
- secs  output  6  remaining seconds, 0..59.
- hundredths  output  7  remaining hundredths, 0..99.
- running  output  1  high in the RUN state.
- alarm  output  1  expiry indication.

## Operation
- Edge detection: each button has a registered previous value, reset to 0. pulse = in & ~prev.
- States: IDLE, RUN, PAUSE, EXPIRED. Reset enters IDLE.
- Reset values: mins, secs, hundredths = 0; preset = 0; divider = 0; alarm = 0; running = 0.
- load pulse, accepted in any state:
  - count ← {min(set_mins,59), min(set_secs,59), 0}; preset register ← the same value.
  - divider cleared, alarm cleared, state → IDLE.
  - If load and startStop pulse in the same cycle, load wins and the startStop pulse is discarded.
- startStop pulse transitions:
  - IDLE → RUN, only if the count is nonzero; otherwise the pulse is ignored. The divider is cleared on this transition.
  - RUN → PAUSE.
  - PAUSE → RUN. The divider resumes from its held value.
  - EXPIRED → IDLE. alarm is cleared and the count stays 00:00.00.
- Divider:
  - Counts only in RUN and holds in PAUSE.
  - A tick is asserted when divider == TICK_DIV-1; the divider then wraps to 0.
- Decrement on each tick, with borrow:
  - hundredths 0 → 99, borrowing from secs.
  - secs 0 → 59, borrowing from mins.
  - A borrow at 00:00.00 is impossible, because the block leaves RUN when the count reaches zero.
- Expiry: on the tick that produces 00:00.00, in the same edge, state → EXPIRED, alarm ← 1 and running ← 0.
- alarm stays high until a startStop pulse, a load pulse or reset.

## Timing
- Button response: state and registers update on the first clk edge at which the input is sampled high with prev low.
- Decrement cadence: the first decrement lands exactly TICK_DIV cycles after the start edge, then one every TICK_DIV cycles while in RUN.
- Pause/resume: total RUN cycles between decrements is always exactly TICK_DIV, regardless of how a pause splits that interval.
- Outputs are registered. mins, secs and hundredths change together on one edge; no intermediate borrow values are visible.
- Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous) and the block re-enters IDLE.

## Configuration
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - On the expiry tick, the count reloads from the preset register instead of reaching 00:00.00.
  - State stays RUN and alarm pulses high for exactly one cycle.
  - EXPIRED is unreachable.
  - A preset of zero cannot start, because the start guard still applies.
- Undefined: expiry behaves as described in Operation (EXPIRED state, alarm held as a level).

## Structure
- Package countdown_pkg:
  - State enumeration.
  - Constants MAX_SECS = 59, MAX_HUND = 99.
  - Widths MIN_W = 6, SEC_W = 6, HUND_W = 7.
- Sub-module countdown_tick_gen:
  - TICK_DIV divider with enable and synchronous clear inputs and a tick output.
  - Width is $clog2(TICK_DIV).
  - Uses the same asynchronous active-low reset_n.
- Edge detectors, the state machine and the borrow chain are inline in countdown_timer.

## Test plan
All scenarios use TICK_DIV = 4.
- Load and first decrement: set 01:00, pulse load, pulse startStop → exactly 4 cycles later the display reads 00:59.99 and running = 1.
- Expiry and acknowledge: load 00:01 and start → after 400 cycles the display reads 00:00.00, alarm = 1, running = 0; pulse startStop → alarm = 0, state IDLE; pulse startStop again → ignored.
- Pause/resume: start, pause 2 cycles after start, hold PAUSE for 50 cycles (count frozen), resume → the next decrement lands 2 cycles after resume.
- Saturation and start guard:
  - set_mins = 63, set_secs = 60, pulse load → 59:59.00.
  - From reset (00:00.00), start → state stays IDLE.
- Collision and reset:
  - load and startStop rising in the same cycle → IDLE with the new preset.
  - Assert reset_n low during RUN → all outputs 0 immediately.
- With COUNTDOWN_AUTO_RELOAD_EN defined: load 00:01 and start → after 400 cycles the display reads 00:01.00, alarm is high for 1 cycle and running stays 1.
